shift_serializer: RTL and testbench
===================================

// Module: shift_serializer
// PURPOSE
//  Parallel-in / serial-out transmitter; the sending end of the serial link that
//  shift_reg receives via its R/L serial inputs. Accepts W-bit words on a
//  valid/ready handshake and emits them one bit per clock, LSB- or MSB-first,
//  with a one-entry holding buffer so consecutive words stream with no idle cycle.
// PARAMETERS
//  W   4   word width in bits (W >= 2); shift counter width = $clog2(W)
// PORTS
//  clk        in   1  system clock, all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  DATA       in   W  parallel word to transmit
//  in_valid   in   1  DATA/msb_first are valid this cycle
//  msb_first  in   1  1: send DATA[W-1] first; 0: send DATA[0] first; captured with word
//  in_ready   out  1  block can accept a word this cycle
//  ser_out    out  1  current serial bit (registered)
//  ser_valid  out  1  ser_out carries a bit; use as receiver shift enable
//  ser_last   out  1  high with the final bit of each word
//  busy       out  1  shifter or holding buffer occupied
// BEHAVIOUR
//  - Reset (clk edge with reset=1): FSM->IDLE, counter=0, hold empty; ser_out=0,
//    ser_valid=0, ser_last=0, busy=0, in_ready=1. Reset mid-word discards the
//    in-flight word and the held word; no partial bits emitted after that edge.
//  - Handshake: word accepted on edge where in_valid & in_ready. in_ready =
//    ~hold_full (combinational from registered state only; no in_valid path).
//  - FSM states: IDLE (shifter empty), SHIFT (emitting bits).
//    IDLE --accept--> SHIFT: word loads shifter directly; hold untouched.
//    SHIFT, count<W-1: shift one bit, count++.
//    SHIFT, count==W-1 (last bit on output): next edge loads shifter from hold if
//      full (hold->empty), else from DATA if accepted same edge, else -> IDLE.
//    SHIFT, accept while not last bit: word goes to hold (hold->full).
//    Simultaneous accept and last bit with hold full: impossible (in_ready=0).
//    Simultaneous accept and last bit with hold empty: accepted word loads shifter
//      directly; hold stays empty.
//  - Latency: word accepted at edge k -> bit0 on ser_out, ser_valid=1, for cycle
//    k+1..; bit i at cycle k+1+i; ser_last=1 at cycle k+W. Back-to-back words:
//    next word's bit0 in cycle immediately after ser_last; ser_valid never drops.
//  - Bit order: msb_first=1 shifts left, emits W-1..0; msb_first=0 shifts right,
//    emits 0..W-1. Order is per-word, latched with that word (held word keeps its own).
//  - ser_out=0 whenever ser_valid=0. busy = (state==SHIFT) | hold_full.
//  - in_valid with in_ready=0: no state change; sender must hold DATA stable.
// TESTING (W=4)
//  1. Reset, DATA=4'b1011, msb_first=0, one-cycle in_valid -> ser_out 1,1,0,1 on
//     4 consecutive cycles starting 1 cycle after accept; ser_last on 4th; then idle.
//  2. Same word, msb_first=1 -> ser_out 1,0,1,1; ser_valid high exactly 4 cycles.
//  3. in_valid held high with 4'hA,4'h5,4'hF (msb_first=1) -> 12 contiguous
//     ser_valid cycles 1010 0101 1111; in_ready low while hold full; ser_last
//     at cycles 4,8,12.
//  4. Mixed order back-to-back: 4'h1 LSB-first then 4'h1 MSB-first -> 1000 0001.
//  5. reset asserted after 2nd bit of 4'hC with a word held -> next cycle
//     ser_valid=0, busy=0, in_ready=1; no remaining bits ever appear.
//  6. Loopback: ser_out into shift_reg serial input (right shift, LSB-first),
//     shift enabled by ser_valid -> shift_reg A equals sent DATA after ser_last
//     for all 16 values.

Source files
------------

// File: rtl/shift_serializer_if.sv
// -----------------------------------------------------------------------------
// shift_serializer_if
// Bundles the word-side handshake and the serial-side outputs of the
// parallel-to-serial transmitter.
//   DATA       W-bit parallel word offered by the sender
//   in_valid   DATA / msb_first are valid this cycle
//   msb_first  bit order for the offered word (1: MSB first)
//   in_ready   transmitter can take a word this cycle
//   ser_out    current serial bit
//   ser_valid  ser_out carries a bit (receiver shift enable)
//   ser_last   final bit of the current word
//   busy       shifter or holding buffer occupied
// Modports: master = word sender / serial observer, slave = transmitter.
// -----------------------------------------------------------------------------
interface shift_serializer_if #(
    parameter int W = 4
);
    logic [W-1:0] DATA;
    logic         in_valid;
    logic         msb_first;
    logic         in_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_last;
    logic         busy;

    modport master (
        output DATA, in_valid, msb_first,
        input  in_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  DATA, in_valid, msb_first,
        output in_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
// Parallel-in / serial-out transmitter. Accepts W-bit words on a valid/ready
// handshake and emits them one bit per clock, LSB- or MSB-first (chosen per
// word). A one-entry holding buffer lets consecutive words stream with no
// idle cycle between the last bit of one word and the first of the next.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    shift_serializer_if.slave (handshake in, serial stream out)
// -----------------------------------------------------------------------------
module shift_serializer #(
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               reset,
    shift_serializer_if.slave  bus
);
    localparam int CW = $clog2(W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   shreg_q;
    logic           dir_q;
    logic [W-1:0]   hold_data_q;
    logic           hold_dir_q;
    logic           hold_full_q;
    logic           ser_out_q;
    logic           ser_valid_q;
    logic           ser_last_q;

    logic           accept;
    logic           last_bit;
    logic           load_from_hold;
    logic [W-1:0]   ld_data;
    logic           ld_dir;
    logic [W-1:0]   shift_d;

    // in_ready depends only on registered state, never on in_valid.
    assign accept   = bus.in_valid & ~hold_full_q;
    assign last_bit = (cnt_q == CW'(W - 1));

    always_comb begin
        // The held word has priority when the current word finishes; a
        // same-edge accept is impossible then because in_ready is low.
        load_from_hold = (state_q == SHIFT) & last_bit & hold_full_q;
        ld_data        = load_from_hold ? hold_data_q : bus.DATA;
        ld_dir         = load_from_hold ? hold_dir_q  : bus.msb_first;
        shift_d        = dir_q ? {shreg_q[W-2:0], 1'b0} : {1'b0, shreg_q[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            dir_q       <= 1'b0;
            hold_data_q <= '0;
            hold_dir_q  <= 1'b0;
            hold_full_q <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // Word goes straight to the shifter; bit0 is
                        // presented on ser_out in the following cycle.
                        state_q     <= SHIFT;
                        shreg_q     <= ld_data;
                        dir_q       <= ld_dir;
                        cnt_q       <= '0;
                        ser_out_q   <= ld_dir ? ld_data[W-1] : ld_data[0];
                        ser_valid_q <= 1'b1;
                        ser_last_q  <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (!last_bit) begin
                        shreg_q    <= shift_d;
                        cnt_q      <= cnt_q + CW'(1);
                        // Next bit is the one adjacent to the outgoing end.
                        ser_out_q  <= dir_q ? shreg_q[W-2] : shreg_q[1];
                        ser_last_q <= (cnt_q == CW'(W - 2));
                        if (accept) begin
                            hold_data_q <= bus.DATA;
                            hold_dir_q  <= bus.msb_first;
                            hold_full_q <= 1'b1;
                        end
                    end else if (hold_full_q || accept) begin
                        // Seamless reload: either the held word or a word
                        // accepted on this very edge.
                        shreg_q     <= ld_data;
                        dir_q       <= ld_dir;
                        cnt_q       <= '0;
                        ser_out_q   <= ld_dir ? ld_data[W-1] : ld_data[0];
                        ser_valid_q <= 1'b1;
                        ser_last_q  <= 1'b0;
                        if (load_from_hold) begin
                            hold_full_q <= 1'b0;
                        end
                    end else begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        ser_out_q   <= 1'b0;
                        ser_valid_q <= 1'b0;
                        ser_last_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = ~hold_full_q;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.busy      = (state_q == SHIFT) | hold_full_q;

endmodule

// File: tb/tb_shift_serializer.sv
// -----------------------------------------------------------------------------
// tb_shift_serializer
// Directed and randomized stimulus for shift_serializer (W=4). The reference
// model is a queue of pending {bit, last} pairs: every accepted word appends
// its W bits in transmit order, and every clock one pair leaves the queue.
// Whether the holding buffer is full follows from how many bits remain queued
// behind the one currently on the wire.
// -----------------------------------------------------------------------------
module tb_shift_serializer;
    localparam int W = 4;

    logic clk;
    logic reset;

    shift_serializer_if #(.W(W)) sif ();

    shift_serializer #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [1:0]  model_q[$];      // {bit, last}
    logic        model_ready = 1'b1;
    logic [31:0] obs;
    int          nobs;
    logic [W-1:0] rx;             // loopback receiver (right shift, LSB first)

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus plus model update and output checks.
    task automatic step(input logic v, input logic [W-1:0] d, input logic m,
                        input logic rst, output logic acc);
        logic [1:0] e;
        logic ev, eb, el;
        sif.in_valid  = v;
        sif.DATA      = d;
        sif.msb_first = m;
        reset         = rst;
        // Receiver shifts on the edge that ends a cycle with ser_valid high.
        if (sif.ser_valid === 1'b1) rx = {sif.ser_out, rx[W-1:1]};
        acc = v && model_ready && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
        end else if (acc) begin
            for (int i = 0; i < W; i++) begin
                model_q.push_back({(m ? d[W-1-i] : d[i]), (i == W - 1)});
            end
        end
        if (model_q.size() > 0) begin
            e  = model_q.pop_front();
            ev = 1'b1;
            eb = e[1];
            el = e[0];
        end else begin
            ev = 1'b0;
            eb = 1'b0;
            el = 1'b0;
        end
        // W or more bits still queued means a whole word sits in the hold.
        model_ready = (model_q.size() < W);
        chk("ser_valid", 32'(sif.ser_valid), 32'(ev));
        chk("ser_out",   32'(sif.ser_out),   32'(eb));
        chk("ser_last",  32'(sif.ser_last),  32'(el));
        chk("in_ready",  32'(sif.in_ready),  32'(model_ready));
        chk("busy",      32'(sif.busy),      32'(ev | !model_ready));
        if (sif.ser_valid === 1'b1) begin
            obs = {obs[30:0], sif.ser_out};
            nobs++;
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, a);
    endtask

    initial begin
        logic a;
        logic [W-1:0] words[3];
        int idx;
        logic pend_v;
        logic [W-1:0] pend_d;
        logic pend_m;

        sif.in_valid  = 1'b0;
        sif.DATA      = '0;
        sif.msb_first = 1'b0;
        reset         = 1'b1;
        obs  = '0;
        nobs = 0;
        rx   = '0;

        // Reset state
        step(1'b0, '0, 1'b0, 1'b1, a);
        step(1'b0, '0, 1'b0, 1'b1, a);
        idle(1);

        // 1: 1011 LSB-first -> 1,1,0,1
        obs = '0; nobs = 0;
        step(1'b1, 4'b1011, 1'b0, 1'b0, a);
        idle(6);
        chk("t1_bits", obs, 32'hD);
        chk("t1_count", 32'(nobs), 32'd4);

        // 2: 1011 MSB-first -> 1,0,1,1
        obs = '0; nobs = 0;
        step(1'b1, 4'b1011, 1'b1, 1'b0, a);
        idle(6);
        chk("t2_bits", obs, 32'hB);
        chk("t2_count", 32'(nobs), 32'd4);

        // 3: in_valid held high with A,5,F MSB-first -> 12 contiguous bits
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF;
        obs = '0; nobs = 0; idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            step(1'b1, words[idx], 1'b1, 1'b0, a);
            if (a) idx++;
        end
        chk("t3_accepted", 32'(idx), 32'd3);
        idle(14);
        chk("t3_bits", obs, 32'hA5F);
        chk("t3_count", 32'(nobs), 32'd12);

        // 4: 1 LSB-first then 1 MSB-first -> 1000 0001
        obs = '0; nobs = 0;
        step(1'b1, 4'h1, 1'b0, 1'b0, a);
        step(1'b1, 4'h1, 1'b1, 1'b0, a);
        idle(10);
        chk("t4_bits", obs, 32'h81);
        chk("t4_count", 32'(nobs), 32'd8);

        // 5: reset after 2nd bit of C with a word held
        step(1'b1, 4'hC, 1'b0, 1'b0, a);
        step(1'b1, 4'h3, 1'b1, 1'b0, a);
        chk("t5_held", 32'(sif.in_ready), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1, a);
        obs = '0; nobs = 0;
        idle(10);
        chk("t5_no_bits", 32'(nobs), 32'd0);

        // 6: loopback into a right-shifting receiver, all 16 values
        for (int v = 0; v < 16; v++) begin
            step(1'b1, W'(v), 1'b0, 1'b0, a);
            idle(W);
            chk("t6_loopback", 32'(rx), 32'(v));
        end
        idle(2);

        // Randomized traffic with occasional reset; sender holds an
        // un-accepted word stable until it is taken.
        pend_v = 1'b0; pend_d = '0; pend_m = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v = 1'b1;
                pend_d = W'($urandom_range(0, (1 << W) - 1));
                pend_m = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 63) == 0) begin
                step(pend_v, pend_d, pend_m, 1'b1, a);
                pend_v = 1'b0;
            end else begin
                step(pend_v, pend_d, pend_m, 1'b0, a);
                if (a) pend_v = 1'b0;
            end
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
